// File: rtl/physics_pkg.sv
// -----------------------------------------------------------------------------
// physics_pkg
//   Shared types for the collision pair scheduler and its neighbours.
//   obb_t        : oriented box record as stored in body RAM
//                  (position 8.24, axes u/v 2.14, half extents 8.24, static flag)
//   contact_t    : record streamed to the solver {idx_a, idx_b, normal, pen}
//   sched_state_e: pair scheduler FSM states (also visible on its debug port)
//   clamp_bodies : limits a requested body count to MAX_BODIES
// -----------------------------------------------------------------------------
package physics_pkg;

    localparam int MAX_BODIES = 16;
    localparam int IDX_W      = $clog2(MAX_BODIES);
    localparam int PEN_W      = 32;
    localparam int NORM_W     = 16;
    localparam int POS_W      = 32;

    typedef struct packed {
        logic signed [POS_W-1:0]  pos_x;
        logic signed [POS_W-1:0]  pos_y;
        logic signed [NORM_W-1:0] u_x;
        logic signed [NORM_W-1:0] u_y;
        logic signed [NORM_W-1:0] v_x;
        logic signed [NORM_W-1:0] v_y;
        logic signed [POS_W-1:0]  half_w;
        logic signed [POS_W-1:0]  half_h;
        logic                     is_static;
    } obb_t;

    typedef struct packed {
        logic [IDX_W-1:0]    idx_a;
        logic [IDX_W-1:0]    idx_b;
        logic [2*NORM_W-1:0] normal;
        logic [PEN_W-1:0]    pen;
    } contact_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_CHECK = 3'd4,
        ST_EMIT  = 3'd5,
        ST_FIN   = 3'd6
    } sched_state_e;

    // Body counts are carried at IDX_W+1 bits so that MAX_BODIES itself fits.
    function automatic logic [IDX_W:0] clamp_bodies(input logic [IDX_W:0] n);
        logic [IDX_W:0] max_n;
        max_n = (IDX_W+1)'(MAX_BODIES);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/collision_pair_scheduler.sv
// -----------------------------------------------------------------------------
// collision_pair_scheduler
//   Walks every unordered body pair (i<j) in lexicographic order, loads both
//   body records from body RAM onto the registered obb1/obb2 detector inputs,
//   samples the external combinational OBB detector and streams one contact
//   per colliding pair to the solver.
//
// Ports
//   Clk, Reset            clock (rising edge), asynchronous active-high reset
//   start, num_bodies     sweep request; body count sampled on start
//   busy, done            sweep in progress / 1-cycle end-of-sweep pulse
//   ram_addr, ram_rd      body RAM read port (data returns the next cycle)
//   ram_data              body record from RAM
//   obb1, obb2            registered detector inputs (body i, body j)
//   det_is_collision, det_normal, det_pen   detector result
//   c_valid, c_ready      contact stream handshake
//   c_idx_a, c_idx_b, c_normal, c_pen       contact payload (a<b)
//   dbg_state             current FSM state
//
// Contact handshake: c_valid rises when a contact is available and, once
// high, stays high with c_idx_a/c_idx_b/c_normal/c_pen unchanged until a
// clock edge where c_valid && c_ready; that edge is the single transfer and
// c_valid is low in the following cycle.
//
// Build option SKIP_STATIC_PAIRS_EN: when defined, a pair whose two bodies are
// both static is dropped in EVAL without sampling the detector.
//
// Pair cost: 3 cycles (RD_B, EVAL, CHECK) for a miss, one more for EMIT plus
// any solver stall for a hit, and one RD_A cycle for each new i. The index
// advance is folded into the CHECK/EMIT exit so it costs no extra cycle.
// -----------------------------------------------------------------------------
module collision_pair_scheduler
    import physics_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [IDX_W:0]      num_bodies,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    ram_addr,
    output logic                ram_rd,
    input  obb_t                ram_data,
    output obb_t                obb1,
    output obb_t                obb2,
    input  logic                det_is_collision,
    input  logic [2*NORM_W-1:0] det_normal,
    input  logic [PEN_W-1:0]    det_pen,
    output logic                c_valid,
    input  logic                c_ready,
    output logic [IDX_W-1:0]    c_idx_a,
    output logic [IDX_W-1:0]    c_idx_b,
    output logic [2*NORM_W-1:0] c_normal,
    output logic [PEN_W-1:0]    c_pen,
    output sched_state_e        dbg_state
);

    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] TWO = (IDX_W+1)'(2);

    sched_state_e   r_state;
    sched_state_e   w_next;
    sched_state_e   w_adv_state;
    logic [IDX_W:0] r_n;
    logic [IDX_W:0] r_i;
    logic [IDX_W:0] r_j;
    logic           r_from_a;
    obb_t           r_obb1;
    obb_t           r_obb2;
    contact_t       r_contact;

    logic [IDX_W:0] w_n_start;
    logic [IDX_W:0] w_j_inc;
    logic [IDX_W:0] w_i_inc;
    logic [IDX_W:0] w_i_plus2;
    logic           w_more_j;
    logic           w_more_i;
    logic           w_advance;

    assign w_n_start = clamp_bodies(num_bodies);
    assign w_j_inc   = r_j + ONE;
    assign w_i_inc   = r_i + ONE;
    assign w_i_plus2 = r_i + TWO;
    assign w_more_j  = (w_j_inc < r_n);
    assign w_more_i  = (w_i_plus2 < r_n);

    // Where the sweep goes once the current pair is finished.
    always_comb begin
        w_adv_state = ST_FIN;
        if (w_more_j) begin
            w_adv_state = ST_RD_B;
        end else if (w_more_i) begin
            w_adv_state = ST_RD_A;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_n_start < TWO) ? ST_FIN : ST_RD_A;
                end
            end
            ST_RD_A: w_next = ST_RD_B;
            ST_RD_B: w_next = ST_EVAL;
            ST_EVAL: begin
                w_next = ST_CHECK;
`ifdef SKIP_STATIC_PAIRS_EN
                // obb1 is already registered; body j is still on ram_data.
                if (r_obb1.is_static && ram_data.is_static) begin
                    w_next    = w_adv_state;
                    w_advance = 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                if (det_is_collision) begin
                    w_next = ST_EMIT;
                end else begin
                    w_next    = w_adv_state;
                    w_advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (c_ready) begin
                    w_next    = w_adv_state;
                    w_advance = 1'b1;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_from_a  <= 1'b0;
            r_obb1    <= '0;
            r_obb2    <= '0;
            r_contact <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n      <= w_n_start;
                        r_i      <= '0;
                        r_j      <= ONE;
                        r_from_a <= 1'b0;
                    end
                end
                ST_RD_A: r_from_a <= 1'b1;
                ST_RD_B: begin
                    // Only a fresh i loads obb1; a j-only step keeps the cached body i.
                    if (r_from_a) begin
                        r_obb1 <= ram_data;
                    end
                    r_from_a <= 1'b0;
                end
                ST_EVAL: r_obb2 <= ram_data;
                ST_CHECK: begin
                    r_contact.idx_a  <= r_i[IDX_W-1:0];
                    r_contact.idx_b  <= r_j[IDX_W-1:0];
                    r_contact.normal <= det_normal;
                    r_contact.pen    <= det_pen;
                end
                default: ;
            endcase
            if (w_advance) begin
                if (w_more_j) begin
                    r_j <= w_j_inc;
                end else if (w_more_i) begin
                    r_i <= w_i_inc;
                    r_j <= w_i_plus2;
                end
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FIN);
    assign ram_rd    = (r_state == ST_RD_A) || (r_state == ST_RD_B);
    assign ram_addr  = (r_state == ST_RD_A) ? r_i[IDX_W-1:0] :
                       (r_state == ST_RD_B) ? r_j[IDX_W-1:0] : '0;
    assign obb1      = r_obb1;
    assign obb2      = r_obb2;
    assign c_valid   = (r_state == ST_EMIT);
    assign c_idx_a   = r_contact.idx_a;
    assign c_idx_b   = r_contact.idx_b;
    assign c_normal  = r_contact.normal;
    assign c_pen     = r_contact.pen;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_pair_scheduler
//   Drives collision_pair_scheduler with a body RAM model and a simple
//   axis-aligned box detector. Expected contacts, RAM read order and sweep
//   length come from a pair-enumeration model built from the body table.
// -----------------------------------------------------------------------------
module tb_collision_pair_scheduler;
    import physics_pkg::*;

    localparam int CW = 2*IDX_W + 2*NORM_W + PEN_W;

    typedef struct packed {
        logic                hit;
        logic [2*NORM_W-1:0] normal;
        logic [PEN_W-1:0]    pen;
    } det_t;

    // ---------------- clock / reset / DUT ----------------
    logic                Clk = 1'b0;
    logic                Reset;
    logic                start;
    logic [IDX_W:0]      num_bodies;
    logic                busy, done, ram_rd;
    logic [IDX_W-1:0]    ram_addr;
    obb_t                ram_data;
    obb_t                obb1, obb2;
    logic                det_is_collision;
    logic [2*NORM_W-1:0] det_normal;
    logic [PEN_W-1:0]    det_pen;
    logic                c_valid, c_ready;
    logic [IDX_W-1:0]    c_idx_a, c_idx_b;
    logic [2*NORM_W-1:0] c_normal;
    logic [PEN_W-1:0]    c_pen;
    sched_state_e        dbg_state;

    always #5 Clk = ~Clk;

    collision_pair_scheduler dut (
        .Clk(Clk), .Reset(Reset), .start(start), .num_bodies(num_bodies),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_data(ram_data), .obb1(obb1), .obb2(obb2),
        .det_is_collision(det_is_collision), .det_normal(det_normal), .det_pen(det_pen),
        .c_valid(c_valid), .c_ready(c_ready), .c_idx_a(c_idx_a), .c_idx_b(c_idx_b),
        .c_normal(c_normal), .c_pen(c_pen), .dbg_state(dbg_state)
    );

    // ---------------- environment: RAM and detector ----------------
    obb_t mem [MAX_BODIES];

    always @(posedge Clk) begin
        if (ram_rd) ram_data <= mem[ram_addr];
    end

    // Axis-aligned overlap; the normal points from a towards b along the
    // axis of least penetration, so swapped inputs give a different answer.
    function automatic det_t det_model(input obb_t a, input obb_t b);
        det_t r;
        logic signed [31:0] dx, dy, adx, ady, ox, oy;
        logic signed [15:0] nv;
        dx  = b.pos_x - a.pos_x;
        dy  = b.pos_y - a.pos_y;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        ox  = a.half_w + b.half_w - adx;
        oy  = a.half_h + b.half_h - ady;
        r.hit = (ox > 0) && (oy > 0);
        if (ox <= oy) begin
            nv = (dx < 0) ? -16'sd16384 : 16'sd16384;
            r.normal = {nv, 16'h0000};
            r.pen    = ox;
        end else begin
            nv = (dy < 0) ? -16'sd16384 : 16'sd16384;
            r.normal = {16'h0000, nv};
            r.pen    = oy;
        end
        return r;
    endfunction

    det_t w_det;
    always_comb w_det = det_model(obb1, obb2);
    assign det_is_collision = w_det.hit;
    assign det_normal       = w_det.normal;
    assign det_pen          = w_det.pen;

    function automatic obb_t mk_body(input int x, input int y, input int hw, input int hh, input bit st);
        obb_t b;
        b           = '0;
        b.pos_x     = x <<< 24;
        b.pos_y     = y <<< 24;
        b.u_x       = 16'sd16384;
        b.v_y       = 16'sd16384;
        b.half_w    = hw <<< 24;
        b.half_h    = hh <<< 24;
        b.is_static = st;
        return b;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [CW-1:0]    exp_q[$];
    logic [CW-1:0]    got_q[$];
    logic [IDX_W-1:0] exp_rd[$];
    logic [IDX_W-1:0] rd_q[$];
    int exp_cycles, exp_visits;
    int done_cnt, valid_cnt, chk_cnt, last_cycles;
    int n_tests = 0;
    int n_fail  = 0;

    // Enumerates pairs (0,1),(0,2)..(n-2,n-1). Sweep length counted in cycles
    // after the start-sampling edge: 1 per new i, 3 per evaluated pair, +1 per
    // hit (ready held high), 2 per skipped static pair, then the done cycle.
    task automatic build_expected(input int n_req);
        int n;
        det_t d;
        bit skip;
        n = (n_req > MAX_BODIES) ? MAX_BODIES : n_req;
        exp_q.delete();
        exp_rd.delete();
        exp_cycles = 0;
        exp_visits = 0;
        for (int i = 0; i + 1 < n; i++) begin
            exp_rd.push_back(IDX_W'(i));
            exp_cycles += 1;
            for (int j = i + 1; j < n; j++) begin
                exp_rd.push_back(IDX_W'(j));
                d = det_model(mem[i], mem[j]);
`ifdef SKIP_STATIC_PAIRS_EN
                skip = mem[i].is_static && mem[j].is_static;
`else
                skip = 1'b0;
`endif
                if (skip) begin
                    exp_cycles += 2;
                end else begin
                    exp_cycles += 3;
                    exp_visits += 1;
                    if (d.hit) begin
                        exp_cycles += 1;
                        exp_q.push_back({IDX_W'(i), IDX_W'(j), d.normal, d.pen});
                    end
                end
            end
        end
        exp_cycles += 1;
    endtask

    always @(negedge Clk) begin
        if (c_valid && c_ready) got_q.push_back({c_idx_a, c_idx_b, c_normal, c_pen});
        if (ram_rd) rd_q.push_back(ram_addr);
        if (done) done_cnt++;
        if (c_valid) valid_cnt++;
        if (dbg_state == ST_CHECK) chk_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        rd_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
        chk_cnt   = 0;
    endtask

    task automatic compare_contacts(input string tag);
        chk({tag, "_contact_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk({tag, "_contact"}, got_q[k], exp_q[k]);
    endtask

    task automatic compare_reads(input string tag);
        chk({tag, "_read_count"}, rd_q.size(), exp_rd.size());
        for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++)
            chk({tag, "_read_addr"}, rd_q[k], exp_rd[k]);
    endtask

    task automatic run_sweep(input int n_req, input bit extra_start, input string tag);
        int cycles;
        bit seen;
        clear_mon();
        build_expected(n_req);
        num_bodies = (IDX_W+1)'(n_req);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_bodies = (IDX_W+1)'($urandom_range(0, 31));
        cycles = 0;
        seen   = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge Clk);
            cycles++;
            if (extra_start && cycles == 3) start = 1'b1;
            if (extra_start && cycles == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1'b1);
        last_cycles = cycles;
        tick();
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        compare_contacts(tag);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if (c_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, seen, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        c_ready    = 1'b1;
        num_bodies = '0;
        for (int k = 0; k < MAX_BODIES; k++) mem[k] = mk_body(40 * k, 0, 1, 1, 1'b0);
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_ram_rd", ram_rd, 1'b0);
        chk("reset_c_valid", c_valid, 1'b0);
        chk("reset_ram_addr", ram_addr, '0);
        chk("reset_c_payload", {c_idx_a, c_idx_b, c_normal, c_pen}, '0);
        chk("reset_obb_zero", (obb1 == '0) && (obb2 == '0), 1'b1);
        chk("reset_state", dbg_state, ST_IDLE);
        Reset = 1'b0;
        tick();

        // n = 0 and n = 1: straight to the done pulse, no reads, no contacts.
        for (int n = 0; n < 2; n++) begin
            run_sweep(n, 1'b0, "small_n");
            chk("small_n_latency", last_cycles, exp_cycles);
            chk("small_n_reads", rd_q.size(), 0);
            chk("small_n_valid", valid_cnt, 0);
        end

        // n = 3, all pairs overlap.
        mem[0] = mk_body(5, 5, 2, 2, 1'b0);
        mem[1] = mk_body(6, 5, 2, 2, 1'b0);
        mem[2] = mk_body(5, 6, 2, 2, 1'b0);
        run_sweep(3, 1'b0, "n3_overlap");
        chk("n3_latency", last_cycles, exp_cycles);
        compare_reads("n3");

        // n = 4, spread out: no contacts, every pair visited once.
        for (int k = 0; k < 4; k++) mem[k] = mk_body(10 * k, 0, 1, 1, 1'b0);
        run_sweep(4, 1'b0, "n4_apart");
        chk("n4_latency", last_cycles, exp_cycles);
        chk("n4_pairs_visited", chk_cnt, 6);
        compare_reads("n4");

        // Solver stall: contact held for 10 cycles, one transfer on release.
        mem[0] = mk_body(3, 3, 2, 2, 1'b0);
        mem[1] = mk_body(4, 3, 2, 2, 1'b0);
        clear_mon();
        build_expected(2);
        c_ready    = 1'b0;
        num_bodies = (IDX_W+1)'(2);
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("stall");
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid_held", c_valid, 1'b1);
            chk("stall_payload_held", {c_idx_a, c_idx_b, c_normal, c_pen}, exp_q[0]);
            @(negedge Clk);
        end
        tick();
        c_ready = 1'b1;
        for (int k = 0; k < 20 && !done; k++) @(negedge Clk);
        chk("stall_done", done, 1'b1);
        chk("stall_valid_after", c_valid, 1'b0);
        compare_contacts("stall");
        tick();

        // Reset while a contact is pending.
        mem[0] = mk_body(5, 5, 2, 2, 1'b0);
        mem[1] = mk_body(6, 5, 2, 2, 1'b0);
        mem[2] = mk_body(5, 6, 2, 2, 1'b0);
        clear_mon();
        c_ready    = 1'b0;
        num_bodies = (IDX_W+1)'(3);
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("rst_emit");
        Reset = 1'b1;
        #1;
        chk("rst_emit_c_valid", c_valid, 1'b0);
        chk("rst_emit_busy", busy, 1'b0);
        chk("rst_emit_ram_rd", ram_rd, 1'b0);
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        chk("rst_emit_no_done", done_cnt, 0);
        chk("rst_emit_no_transfer", got_q.size(), 0);
        c_ready = 1'b1;
        run_sweep(3, 1'b0, "post_reset");
        compare_reads("post_reset");

        // Static bodies 0 and 1 overlap; body 2 overlaps both.
        mem[0] = mk_body(5, 5, 2, 2, 1'b1);
        mem[1] = mk_body(6, 5, 2, 2, 1'b1);
        mem[2] = mk_body(5, 6, 2, 2, 1'b0);
        run_sweep(3, 1'b0, "static");
        chk("static_latency", last_cycles, exp_cycles);
        chk("static_pairs_visited", chk_cnt, exp_visits);

        // Random bodies, random solver back-pressure, including clamped counts
        // and a start pulse while busy.
        for (int t = 0; t < 6; t++) begin
            int n_tab [6];
            n_tab = '{2, 5, 16, 20, 9, 31};
            for (int k = 0; k < MAX_BODIES; k++)
                mem[k] = mk_body($urandom_range(0, 12), $urandom_range(0, 12),
                                 $urandom_range(1, 3), $urandom_range(1, 3),
                                 1'($urandom_range(0, 1)));
            fork
                begin
                    run_sweep(n_tab[t], (t == 1), "random");
                end
                begin
                    for (int c = 0; c < 4000 && !(done === 1'b1); c++) begin
                        @(posedge Clk);
                        #2;
                        c_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            c_ready = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
